// File: rtl/arbiter_requester_pkg.sv
// ============================================================================
// Module  : arbiter_requester_pkg
// Brief   : Shared FSM state and request-class encodings for the requester.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    CLASS_NORMAL   = 1'b0,
    CLASS_PRIORITY = 1'b1
  } class_e;

  // The request line is held through the transfer beat as well as the wait.
  function automatic logic req_active(input state_t s);
    return (s == ST_REQ) || (s == ST_XFER);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_requester_if.sv
// ============================================================================
// Module  : arbiter_requester_if
// Brief   : Command, arbiter handshake and bus pins of the requester agent.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbiter_requester_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_priority;
  logic [DATA_WIDTH-1:0]        cmd_data;
  logic                         req_priority;
  logic                         req_normal;
  logic                         grant_priority;
  logic                         grant_normal;
  logic                         bus_valid;
  logic [DATA_WIDTH-1:0]        bus_data;
  logic                         bus_priority;
  logic                         timeout_pulse;
  logic [$clog2(DEPTH+1)-1:0]   prio_count;
  logic [$clog2(DEPTH+1)-1:0]   norm_count;

  // master: the requester agent itself
  modport master (
    input  cmd_valid, cmd_priority, cmd_data, grant_priority, grant_normal,
    output cmd_ready, req_priority, req_normal, bus_valid, bus_data,
           bus_priority, timeout_pulse, prio_count, norm_count
  );

  // slave: the command source, arbiter and bus sink around it
  modport slave (
    output cmd_valid, cmd_priority, cmd_data, grant_priority, grant_normal,
    input  cmd_ready, req_priority, req_normal, bus_valid, bus_data,
           bus_priority, timeout_pulse, prio_count, norm_count
  );

endinterface

`default_nettype wire

// File: rtl/arbiter_requester_req_fifo.sv
// ============================================================================
// Module  : arbiter_requester_req_fifo
// Brief   : Per-class command FIFO, power-of-two depth, registered occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_requester_req_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic [DATA_WIDTH-1:0]      push_data,
  input  wire logic                       pop,
  output logic      [DATA_WIDTH-1:0]      head,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/arbiter_requester.sv
// ============================================================================
// Module  : arbiter_requester
// Brief   : Requester-side agent: per-class queues, request/grant FSM, bus beat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_requester
  import arbiter_requester_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  arbiter_requester_if.master rq
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t                state_q, state_d;
  class_e                class_q, class_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  req_priority_q, req_priority_d;
  logic                  req_normal_q, req_normal_d;
  logic                  bus_valid_q, bus_valid_d;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic                  bus_priority_q, bus_priority_d;

  logic [DATA_WIDTH-1:0] prio_head, norm_head;
  logic                  prio_full, norm_full;
  logic                  prio_empty, norm_empty;
  logic [CNT_W-1:0]      prio_count, norm_count;
  logic                  push_prio, push_norm;
  logic                  pop_prio, pop_norm;
  logic                  cmd_ready;
  logic                  grant_mine;
  logic                  timeout_hit;

  assign cmd_ready  = !rst && (rq.cmd_priority ? !prio_full : !norm_full);
  assign push_prio  = rq.cmd_valid && cmd_ready && rq.cmd_priority;
  assign push_norm  = rq.cmd_valid && cmd_ready && !rq.cmd_priority;
  assign grant_mine = (class_q == CLASS_PRIORITY) ? rq.grant_priority : rq.grant_normal;

  arbiter_requester_req_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_prio_fifo (
    .clk(clk), .rst(rst), .push(push_prio), .push_data(rq.cmd_data), .pop(pop_prio),
    .head(prio_head), .full(prio_full), .empty(prio_empty), .count(prio_count)
  );

  arbiter_requester_req_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_norm_fifo (
    .clk(clk), .rst(rst), .push(push_norm), .push_data(rq.cmd_data), .pop(pop_norm),
    .head(norm_head), .full(norm_full), .empty(norm_empty), .count(norm_count)
  );

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    wait_d      = '0;
    timeout_hit = 1'b0;
    pop_prio    = 1'b0;
    pop_norm    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!prio_empty) begin
          state_d = ST_REQ;
          class_d = CLASS_PRIORITY;
        end else if (!norm_empty) begin
          state_d = ST_REQ;
          class_d = CLASS_NORMAL;
        end
      end
      ST_REQ: begin
        wait_d = wait_q + 1'b1;
        // A grant in the same cycle wins over both timeout and preemption.
        if (grant_mine) begin
          state_d = ST_XFER;
        end else begin
          if (wait_q == WAIT_W'(TIMEOUT-1)) begin
            timeout_hit = 1'b1;
            state_d     = ST_RELEASE;
          end
          if ((class_q == CLASS_NORMAL) && !prio_empty) state_d = ST_RELEASE;
        end
      end
      ST_XFER: begin
        pop_prio = (class_q == CLASS_PRIORITY);
        pop_norm = (class_q == CLASS_NORMAL);
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    req_priority_d = req_active(state_d) && (class_d == CLASS_PRIORITY);
    req_normal_d   = req_active(state_d) && (class_d == CLASS_NORMAL);
    bus_valid_d    = (state_d == ST_XFER);
    bus_priority_d = (state_d == ST_XFER) && (class_d == CLASS_PRIORITY);
    bus_data_d     = '0;
    if (state_d == ST_XFER) bus_data_d = (class_d == CLASS_PRIORITY) ? prio_head : norm_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      class_q        <= CLASS_NORMAL;
      wait_q         <= '0;
      req_priority_q <= 1'b0;
      req_normal_q   <= 1'b0;
      bus_valid_q    <= 1'b0;
      bus_data_q     <= '0;
      bus_priority_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      class_q        <= class_d;
      wait_q         <= wait_d;
      req_priority_q <= req_priority_d;
      req_normal_q   <= req_normal_d;
      bus_valid_q    <= bus_valid_d;
      bus_data_q     <= bus_data_d;
      bus_priority_q <= bus_priority_d;
    end
  end

  assign rq.cmd_ready     = cmd_ready;
  assign rq.req_priority  = req_priority_q;
  assign rq.req_normal    = req_normal_q;
  assign rq.bus_valid     = bus_valid_q;
  assign rq.bus_data      = bus_data_q;
  assign rq.bus_priority  = bus_priority_q;
  assign rq.timeout_pulse = timeout_hit && !rst;
  assign rq.prio_count    = prio_count;
  assign rq.norm_count    = norm_count;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_requester.sv
// ============================================================================
// Module  : tb_arbiter_requester
// Brief   : Directed and randomized self-checking bench with a stub arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter_requester;

  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_requester_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) rq ();

  arbiter_requester #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .rq (rq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Stub arbiter: grants the cycle after a request is first seen, unless withheld.
  logic hold_p = 1'b0, hold_n = 1'b0;
  logic prev_rp = 1'b0, prev_rn = 1'b0;
  always @(posedge clk) begin
    #1;
    rq.grant_priority = prev_rp && rq.req_priority && !hold_p;
    rq.grant_normal   = prev_rn && rq.req_normal && !hold_n;
    prev_rp = rq.req_priority;
    prev_rn = rq.req_normal;
  end

  // Reference queues: what has been accepted and not yet seen on the bus.
  logic [DW-1:0] mq_p[$];
  logic [DW-1:0] mq_n[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic prio, input logic [DW-1:0] data);
    rq.cmd_valid    = 1'b1;
    rq.cmd_priority = prio;
    rq.cmd_data     = data;
    #1;
    chk("send_ready", rq.cmd_ready, 1'b1);
    cyc();
    rq.cmd_valid = 1'b0;
  endtask

  task automatic wait_bus(input string tag, input logic [DW-1:0] exp_data, input logic exp_prio);
    int k = 0;
    while (!rq.bus_valid && k < 40) begin
      cyc();
      k++;
    end
    chk({tag, "_seen"}, rq.bus_valid, 1'b1);
    chk({tag, "_data"}, rq.bus_data, exp_data);
    chk({tag, "_prio"}, rq.bus_priority, exp_prio);
    cyc();
  endtask

  // One cycle of scoreboard checking against the reference queues.
  task automatic observe();
    logic exp_ready;
    chk("rnd_prio_count", rq.prio_count, mq_p.size());
    chk("rnd_norm_count", rq.norm_count, mq_n.size());
    exp_ready = rq.cmd_priority ? (mq_p.size() < DEPTH) : (mq_n.size() < DEPTH);
    chk("rnd_ready", rq.cmd_ready, exp_ready);
    chk("rnd_req_exclusive", rq.req_priority && rq.req_normal, 1'b0);
    if (rq.bus_valid) begin
      if (rq.bus_priority) begin
        chk("rnd_bus_p_nonempty", mq_p.size() > 0, 1'b1);
        if (mq_p.size() > 0) chk("rnd_bus_p_data", rq.bus_data, mq_p.pop_front());
      end else begin
        chk("rnd_bus_n_nonempty", mq_n.size() > 0, 1'b1);
        if (mq_n.size() > 0) chk("rnd_bus_n_data", rq.bus_data, mq_n.pop_front());
      end
    end
    if (rq.cmd_valid && rq.cmd_ready) begin
      if (rq.cmd_priority) mq_p.push_back(rq.cmd_data);
      else                 mq_n.push_back(rq.cmd_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    int k;

    // 1: reset held two cycles with a command offered
    rst             = 1'b1;
    rq.cmd_valid    = 1'b1;
    rq.cmd_priority = 1'b1;
    rq.cmd_data     = 8'hAA;
    cyc();
    cyc();
    #1;
    chk("rst_ready", rq.cmd_ready, 1'b0);
    chk("rst_req_p", rq.req_priority, 1'b0);
    chk("rst_req_n", rq.req_normal, 1'b0);
    chk("rst_bus_valid", rq.bus_valid, 1'b0);
    chk("rst_timeout", rq.timeout_pulse, 1'b0);
    chk("rst_prio_count", rq.prio_count, 0);
    chk("rst_norm_count", rq.norm_count, 0);
    rst          = 1'b0;
    rq.cmd_valid = 1'b0;
    cyc();
    #1;
    chk("post_rst_prio_count", rq.prio_count, 0);
    chk("post_rst_ready", rq.cmd_ready, 1'b1);
    cyc();
    cyc();
    chk("post_rst_no_req", rq.req_priority, 1'b0);

    // 2: single normal command, cycle-exact handshake
    send(1'b0, 8'h5A);
    #1;
    chk("t2_count_n1", rq.norm_count, 1);
    chk("t2_req_n1", rq.req_normal, 1'b0);
    cyc();
    chk("t2_req_n2", rq.req_normal, 1'b1);
    chk("t2_req_p2", rq.req_priority, 1'b0);
    cyc();
    cyc();
    chk("t2_bus_valid", rq.bus_valid, 1'b1);
    chk("t2_bus_data", rq.bus_data, 8'h5A);
    chk("t2_bus_prio", rq.bus_priority, 1'b0);
    chk("t2_req_in_xfer", rq.req_normal, 1'b1);
    cyc();
    chk("t2_bus_valid_off", rq.bus_valid, 1'b0);
    chk("t2_req_release", rq.req_normal, 1'b0);
    chk("t2_count_n0", rq.norm_count, 0);
    cyc();

    // 3: normal request preempted by a later priority command
    hold_n = 1'b1;
    send(1'b0, 8'h11);
    cyc();
    chk("t3_req_n", rq.req_normal, 1'b1);
    send(1'b1, 8'h22);
    #1;
    chk("t3_req_n_still", rq.req_normal, 1'b1);
    chk("t3_prio_count", rq.prio_count, 1);
    cyc();
    chk("t3_release_n", rq.req_normal, 1'b0);
    chk("t3_release_p", rq.req_priority, 1'b0);
    cyc();
    cyc();
    chk("t3_req_p", rq.req_priority, 1'b1);
    chk("t3_req_n_off", rq.req_normal, 1'b0);
    hold_n = 1'b0;
    wait_bus("t3_first", 8'h22, 1'b1);
    wait_bus("t3_second", 8'h11, 1'b0);
    cyc();

    // 4: grant timeout and retry
    hold_p = 1'b1;
    send(1'b1, 8'h33);
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc();
      #1;
      chk("t4_req_p_wait", rq.req_priority, 1'b1);
      chk("t4_timeout", rq.timeout_pulse, (i == TIMEOUT - 1));
    end
    cyc();
    #1;
    chk("t4_release", rq.req_priority, 1'b0);
    chk("t4_pulse_once", rq.timeout_pulse, 1'b0);
    cyc();
    chk("t4_idle", rq.req_priority, 1'b0);
    cyc();
    chk("t4_rerequest", rq.req_priority, 1'b1);
    hold_p = 1'b0;
    wait_bus("t4_xfer", 8'h33, 1'b1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (rq.bus_valid) extra++;
      cyc();
    end
    chk("t4_no_duplicate", extra, 0);
    chk("t4_prio_empty", rq.prio_count, 0);

    // 5: priority FIFO full
    hold_p = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(1'b1, 8'hC0 + 8'(i));
    #1;
    chk("t5_prio_full", rq.prio_count, DEPTH);
    rq.cmd_priority = 1'b1;
    #1;
    chk("t5_ready_p", rq.cmd_ready, 1'b0);
    rq.cmd_priority = 1'b0;
    #1;
    chk("t5_ready_n", rq.cmd_ready, 1'b1);
    rq.cmd_valid    = 1'b1;
    rq.cmd_priority = 1'b1;
    rq.cmd_data     = 8'h99;
    #1;
    chk("t5_fifth_ready", rq.cmd_ready, 1'b0);
    cyc();
    rq.cmd_valid = 1'b0;
    #1;
    chk("t5_fifth_dropped", rq.prio_count, DEPTH);
    hold_p = 1'b0;
    for (int i = 0; i < DEPTH; i++) wait_bus("t5_drain", 8'hC0 + 8'(i), 1'b1);
    cyc();
    chk("t5_drained", rq.prio_count, 0);

    // 6: reset during a transfer beat
    hold_p = 1'b1;
    hold_n = 1'b1;
    send(1'b0, 8'h44);
    send(1'b1, 8'h55);
    send(1'b1, 8'h66);
    hold_p = 1'b0;
    k = 0;
    while (!rq.bus_valid && k < 40) begin
      cyc();
      k++;
    end
    chk("t6_xfer_seen", rq.bus_valid, 1'b1);
    chk("t6_xfer_data", rq.bus_data, 8'h55);
    rst = 1'b1;
    cyc();
    #1;
    chk("t6_bus_valid", rq.bus_valid, 1'b0);
    chk("t6_req_p", rq.req_priority, 1'b0);
    chk("t6_req_n", rq.req_normal, 1'b0);
    chk("t6_prio_count", rq.prio_count, 0);
    chk("t6_norm_count", rq.norm_count, 0);
    chk("t6_ready", rq.cmd_ready, 1'b0);
    rst    = 1'b0;
    hold_n = 1'b0;
    extra  = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (rq.bus_valid || rq.req_priority || rq.req_normal) extra++;
    end
    chk("t6_nothing_reappears", extra, 0);

    // Randomized traffic against the reference queues
    for (int i = 0; i < 600; i++) begin
      rq.cmd_valid    = ($urandom_range(0, 99) < 50);
      rq.cmd_priority = ($urandom_range(0, 99) < 35);
      rq.cmd_data     = DW'($urandom);
      hold_p          = ($urandom_range(0, 99) < 20);
      hold_n          = ($urandom_range(0, 99) < 30);
      #1;
      observe();
      cyc();
    end
    rq.cmd_valid = 1'b0;
    hold_p       = 1'b0;
    hold_n       = 1'b0;
    k = 0;
    while ((mq_p.size() > 0 || mq_n.size() > 0) && k < 400) begin
      #1;
      observe();
      cyc();
      k++;
    end
    chk("drain_model_p", mq_p.size(), 0);
    chk("drain_model_n", mq_n.size(), 0);
    #1;
    chk("drain_prio_count", rq.prio_count, 0);
    chk("drain_norm_count", rq.norm_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
